// File: rtl/ni_apb_top.sv
// NoC flit port to APB requester bridge: gathers a 6-flit request, runs one APB
// transfer, and streams a 4-flit response back to the NoC.

package ni_pkg;
    localparam int TOTAL_FLITS = 6;
    localparam int FLIT_W      = 16;
    localparam int RESP_FLITS  = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] tag;
    } ni_req_s;
endpackage

package apb_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        psel;
        logic        penable;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_req_s;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_resp_s;
endpackage

package fsm_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_e;
endpackage

module ni_apb_top
    import ni_pkg::*;
    import apb_pkg::*;
    import fsm_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic [15:0] i_flit,
    input  logic      enable,
    output logic [15:0] o_flit,
    output logic      ready,
    output logic      valid_out,
    input  apb_resp_s apb_resp_signals,
    output apb_req_s  apb_req_signals
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  rcnt_q, rcnt_d;
    ni_req_s     req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    apb_req_s    apb_q, apb_d;
    flit_t       o_flit_q, o_flit_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        accept;

    assign accept = enable && ready_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            req_q    <= '0;
            rdata_q  <= '0;
            apb_q    <= '0;
            o_flit_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            apb_q    <= apb_d;
            o_flit_q <= o_flit_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Next values for every output register are formed here so that all
    // outputs change on the same edge as the state they belong to.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        apb_d    = apb_q;
        o_flit_d = o_flit_q;
        ready_d  = ready_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.src  = i_flit[15:12];
                    req_d.dest = i_flit[11:8];
                    req_d.wr   = i_flit[7];
                    cnt_d      = 3'd1;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    case (cnt_q)
                        3'd1:    req_d.addr[31:16]  = i_flit;
                        3'd2:    req_d.addr[15:0]   = i_flit;
                        3'd3:    req_d.wdata[31:16] = i_flit;
                        3'd4:    req_d.wdata[15:0]  = i_flit;
                        default: req_d.tag          = i_flit;
                    endcase
                    if (cnt_q == 3'(TOTAL_FLITS - 1)) begin
                        // Tail: launch SETUP directly from the captured fields.
                        cnt_d          = '0;
                        state_d        = SETUP;
                        ready_d        = 1'b0;
                        apb_d.psel     = 1'b1;
                        apb_d.penable  = 1'b0;
                        apb_d.paddr    = req_q.addr;
                        apb_d.pwrite   = req_q.wr;
                        apb_d.pwdata   = req_q.wr ? req_q.wdata : 32'h0;
                        apb_d.pstrb    = 4'hF;
                        apb_d.pprot    = 3'b000;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            SETUP: begin
                apb_d.penable = 1'b1;
                state_d       = ACCESS;
            end
            ACCESS: begin
                if (apb_resp_signals.pready) begin
                    apb_d.psel    = 1'b0;
                    apb_d.penable = 1'b0;
                    rdata_d       = req_q.wr ? 32'h0 : apb_resp_signals.prdata;
                    o_flit_d      = {req_q.dest, req_q.src, req_q.wr,
                                     apb_resp_signals.pslverr, 6'b0};
                    valid_d       = 1'b1;
                    rcnt_d        = '0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                rcnt_d = rcnt_q + 2'd1;
                case (rcnt_q)
                    2'd0: o_flit_d = rdata_q[31:16];
                    2'd1: o_flit_d = rdata_q[15:0];
                    2'd2: o_flit_d = req_q.tag;
                    default: begin
                        o_flit_d = '0;
                        valid_d  = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_flit          = o_flit_q;
    assign ready           = ready_q;
    assign valid_out       = valid_q;
    assign apb_req_signals = apb_q;

endmodule

// File: tb/tb_ni_apb_top.sv
// Directed and randomized packets for ni_apb_top, checked against a packet-level
// reference model of the expected APB transfer and response flits.

module tb_ni_apb_top;
    import apb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] i_flit = '0;
    logic        enable = 1'b0;
    logic [15:0] o_flit;
    logic        ready;
    logic        valid_out;
    apb_resp_s   apb_resp = '0;
    apb_req_s    apb_req;

    int n_assert = 0;
    int n_fail   = 0;

    ni_apb_top dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_flit           (i_flit),
        .enable           (enable),
        .o_flit           (o_flit),
        .ready            (ready),
        .valid_out        (valid_out),
        .apb_resp_signals (apb_resp),
        .apb_req_signals  (apb_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_o_flit", o_flit, 0);
        check("rst_valid", valid_out, 0);
        check("rst_ready", ready, 1);
        check("rst_psel", apb_req.psel, 0);
        check("rst_penable", apb_req.penable, 0);
        check("rst_paddr", apb_req.paddr, 0);
        check("rst_pwdata", apb_req.pwdata, 0);
        check("rst_pwrite", apb_req.pwrite, 0);
        check("rst_pstrb", apb_req.pstrb, 0);
        check("rst_pprot", apb_req.pprot, 0);
    endtask

    // One full request/response exchange; expected values come from the
    // packet fields only. Called at a negedge with the bridge idle.
    task automatic run_txn(input logic [15:0] head, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [15:0] tag,
                           input logic [31:0] rdata, input logic err,
                           input int waits, input int gap);
        logic [15:0] flits [6];
        logic [15:0] exp_q [$];
        logic        wr;
        logic [31:0] exp_wdata;
        wr        = head[7];
        exp_wdata = wr ? wdata : 32'h0;
        flits     = '{head, addr[31:16], addr[15:0], wdata[31:16], wdata[15:0], tag};
        exp_q     = {};
        exp_q.push_back({head[11:8], head[15:12], wr, err, 6'b0});
        exp_q.push_back(wr ? 16'h0 : rdata[31:16]);
        exp_q.push_back(wr ? 16'h0 : rdata[15:0]);
        exp_q.push_back(tag);

        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                for (int g = 0; g < gap; g++) begin
                    enable = 1'b0;
                    i_flit = 16'($urandom);
                    step();
                    check("gap_psel", apb_req.psel, 0);
                    check("gap_ready", ready, 1);
                end
            end
            check("rx_ready", ready, 1);
            enable = 1'b1;
            i_flit = flits[i];
            step();
            if (i < 5) check("rx_no_psel", apb_req.psel, 0);
        end
        enable = 1'b0;
        i_flit = 16'($urandom);

        // SETUP
        check("setup_ready", ready, 0);
        check("setup_psel", apb_req.psel, 1);
        check("setup_penable", apb_req.penable, 0);
        check("setup_paddr", apb_req.paddr, addr);
        check("setup_pwrite", apb_req.pwrite, 32'(wr));
        check("setup_pwdata", apb_req.pwdata, exp_wdata);
        check("setup_pstrb", apb_req.pstrb, 4'hF);
        check("setup_pprot", apb_req.pprot, 0);
        apb_resp.prdata  = rdata;
        apb_resp.pslverr = err;
        apb_resp.pready  = (waits == 0);
        enable = 1'b1;  // ignored while ready is low
        step();

        // ACCESS, first cycle
        check("acc_psel", apb_req.psel, 1);
        check("acc_penable", apb_req.penable, 1);
        check("acc_paddr", apb_req.paddr, addr);
        check("acc_pwdata", apb_req.pwdata, exp_wdata);
        check("acc_pwrite", apb_req.pwrite, 32'(wr));
        for (int k = 0; k < waits; k++) begin
            step();
            check("wait_penable", apb_req.penable, 1);
            check("wait_psel", apb_req.psel, 1);
            check("wait_valid", valid_out, 0);
            check("wait_paddr", apb_req.paddr, addr);
            if (k == waits - 1) apb_resp.pready = 1'b1;
        end
        step();
        enable = 1'b0;
        apb_resp = '{prdata: $urandom, pready: 1'b0, pslverr: 1'b0};
        check("done_psel", apb_req.psel, 0);
        check("done_penable", apb_req.penable, 0);

        for (int r = 0; r < 4; r++) begin
            check("resp_valid", valid_out, 1);
            check("resp_ready", ready, 0);
            check($sformatf("resp_flit%0d", r), o_flit, exp_q.pop_front());
            if (r < 3) step();
        end
        step();
        check("end_valid", valid_out, 0);
        check("end_ready", ready, 1);
    endtask

    initial begin
        logic [15:0] head;
        repeat (2) @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        step();
        check_reset_vals();

        // Write, zero wait
        run_txn(16'h1280, 32'h0000_0010, 32'hDEAD_BEEF, 16'h00A5, 32'h0, 1'b0, 0, 0);
        // Read
        run_txn(16'h1200, 32'h0000_0020, 32'hCAFE_F00D, 16'h005A, 32'h1234_5678, 1'b0, 0, 0);
        // Wait states
        run_txn(16'h34FF, 32'h8000_0004, 32'h0BAD_F00D, 16'h1111, 32'h0, 1'b0, 3, 0);
        run_txn(16'h3470, 32'h8000_0008, 32'h0, 16'h2222, 32'hA5A5_5A5A, 1'b0, 3, 0);
        // Slave error on write
        run_txn(16'h1280, 32'h0000_0030, 32'h0000_0001, 16'h0042, 32'h0, 1'b1, 0, 0);
        // Gap between Body1 and Body2
        run_txn(16'h5A80, 32'h1234_0000, 32'h8765_4321, 16'hBEEF, 32'h0, 1'b0, 0, 2);

        // Reset after three flits of a packet
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            i_flit = (i == 0) ? 16'h1280 : 16'hFFFF;
            step();
        end
        enable = 1'b0;
        resetn = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_psel", apb_req.psel, 0);
            check("post_rst_valid", valid_out, 0);
        end
        run_txn(16'h9600, 32'h0000_0100, 32'h0, 16'h7777, 32'hFEED_FACE, 1'b0, 0, 0);

        // Randomized packets
        for (int n = 0; n < 10; n++) begin
            head = 16'($urandom);
            run_txn(head, $urandom, $urandom, 16'($urandom), $urandom,
                    1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
